// File: rtl/io_port_pkg.sv
// Shared definitions for the board I/O port blocks.
//   SEL_*       : read-select codes presented on rd_sel
//   debState_t  : per-bit debounce state encoding
package io_port_pkg;

  localparam logic [1:0] SEL_LEVEL  = 2'd0;
  localparam logic [1:0] SEL_RISE   = 2'd1;
  localparam logic [1:0] SEL_FALL   = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } debState_t;

endpackage

// File: rtl/sw_input_port_debounce_bit.sv
// debounce_bit: one switch/button bit.
//   clk, rstn  : clock, synchronous active-low reset
//   swRaw      : raw asynchronous level
//   stable     : debounced level (registered)
//   commit     : high in the cycle whose clock edge will update `stable`
//   commitRise : direction of that update (1 = rising, 0 = falling)
// commit/commitRise are combinational so the owner can set its event flags on
// the same edge that `stable` changes.
module debounce_bit import io_port_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic rstn,
  input  logic swRaw,
  output logic stable,
  output logic commit,
  output logic commitRise
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  debState_t        state;
  logic [CNT_W-1:0] cnt;

  // The level has now differed for DEBOUNCE_CYCLES consecutive cycles.
  assign commit     = (state == ST_COUNTING) && (s2 != stable) && (cnt == LAST_CNT);
  assign commitRise = s2;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      state  <= ST_STABLE;
      cnt    <= '0;
    end else begin
      s1 <= swRaw;
      s2 <= s1;
      case (state)
        ST_STABLE: begin
          if (s2 != stable) begin
            state <= ST_COUNTING;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        ST_COUNTING: begin
          if (s2 == stable) begin
            // glitch: level went back before it was accepted
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == LAST_CNT) begin
            stable <= s2;
            state  <= ST_STABLE;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sw_input_port.sv
// sw_input_port: switch/button input peripheral for the CPU core.
//   clk, rstn   : clock, synchronous active-low reset
//   sw_i        : raw switch/button levels (asynchronous)
//   rd_en       : CPU read strobe (one cycle per access)
//   rd_sel      : 0 levels, 1 rise flags, 2 fall flags, 3 status
//   rd_data     : registered read data, zero-extended to 32 bits
//   rd_valid    : one-cycle pulse the cycle after an accepted rd_en
//   sw_stable   : debounced levels
//   evt_pending : OR of all sticky rise/fall flags
// Rise/fall flags are sticky and cleared by reading them; a flag set on the
// same edge as its clear survives, so no event is ever lost.
module sw_input_port import io_port_pkg::*; #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 24
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] sw_i,
  input  logic             rd_en,
  input  logic [1:0]       rd_sel,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic [WIDTH-1:0] sw_stable,
  output logic             evt_pending
);

  logic [WIDTH-1:0] commitVec;
  logic [WIDTH-1:0] dirVec;
  logic [WIDTH-1:0] riseFlags;
  logic [WIDTH-1:0] fallFlags;
  logic [WIDTH-1:0] riseSet;
  logic [WIDTH-1:0] fallSet;
  logic [WIDTH-1:0] riseClr;
  logic [WIDTH-1:0] fallClr;
  logic [WIDTH-1:0] riseNext;
  logic [WIDTH-1:0] fallNext;
  logic [31:0]      readValue;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_deb (
        .clk       (clk),
        .rstn      (rstn),
        .swRaw     (sw_i[gi]),
        .stable    (sw_stable[gi]),
        .commit    (commitVec[gi]),
        .commitRise(dirVec[gi])
      );
    end
  endgenerate

  assign riseSet = commitVec & dirVec;
  assign fallSet = commitVec & ~dirVec;

  // Read mux and clear-on-read. Only the bits actually returned are cleared,
  // which is every currently set bit of the selected flag word.
  always_comb begin
    readValue = '0;
    riseClr   = '0;
    fallClr   = '0;
    case (rd_sel)
      SEL_LEVEL:  readValue = 32'(sw_stable);
      SEL_RISE: begin
        readValue = 32'(riseFlags);
        riseClr   = rd_en ? riseFlags : '0;
      end
      SEL_FALL: begin
        readValue = 32'(fallFlags);
        fallClr   = rd_en ? fallFlags : '0;
      end
      default:    readValue = {30'b0, |fallFlags, |riseFlags};
    endcase
  end

  // Set is applied after clear so a same-cycle set wins.
  assign riseNext = (riseFlags & ~riseClr) | riseSet;
  assign fallNext = (fallFlags & ~fallClr) | fallSet;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      riseFlags   <= '0;
      fallFlags   <= '0;
      evt_pending <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
    end else begin
      riseFlags   <= riseNext;
      fallFlags   <= fallNext;
      evt_pending <= (|riseNext) | (|fallNext);
      rd_valid    <= rd_en;
      if (rd_en) begin
        rd_data <= readValue;
      end
    end
  end

endmodule

// File: tb/tb_sw_input_port.sv
// Testbench for sw_input_port with DEBOUNCE_CYCLES=8. A reference model
// tracks, per bit, how long the two-cycle-delayed input has disagreed with
// the accepted level; read results are queued and checked by a monitor.
module tb_sw_input_port;

  localparam int WIDTH = 16;
  localparam int DEB   = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [WIDTH-1:0] sw_i = '0;
  logic             rd_en = 1'b0;
  logic [1:0]       rd_sel = 2'd0;
  logic [31:0]      rd_data;
  logic             rd_valid;
  logic [WIDTH-1:0] sw_stable;
  logic             evt_pending;

  sw_input_port #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (4)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .sw_i       (sw_i),
    .rd_en      (rd_en),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .sw_stable  (sw_stable),
    .evt_pending(evt_pending)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] mStable  = '0;
  logic [WIDTH-1:0] mRise    = '0;
  logic [WIDTH-1:0] mFall    = '0;
  logic [WIDTH-1:0] h1       = '0;  // sw_i seen one edge ago
  logic [WIDTH-1:0] h2       = '0;  // sw_i seen two edges ago
  int               run[WIDTH];
  logic             expValid = 1'b0;
  logic [31:0]      lastData = '0;
  logic [31:0]      expQ[$];

  always @(posedge clk) begin
    logic [31:0] d;
    if (!rstn) begin
      mStable  = '0;
      mRise    = '0;
      mFall    = '0;
      h1       = '0;
      h2       = '0;
      expValid = 1'b0;
      lastData = '0;
      for (int i = 0; i < WIDTH; i++) run[i] = 0;
      expQ.delete();
    end else begin
      expValid = rd_en;
      if (rd_en) begin
        case (rd_sel)
          2'd0: d = {16'b0, mStable};
          2'd1: begin d = {16'b0, mRise}; mRise = '0; end
          2'd2: begin d = {16'b0, mFall}; mFall = '0; end
          default: d = {30'b0, |mFall, |mRise};
        endcase
        expQ.push_back(d);
        lastData = d;
      end
      // a level is accepted once it has disagreed DEB cycles in a row
      for (int i = 0; i < WIDTH; i++) begin
        if (h2[i] != mStable[i]) begin
          run[i]++;
          if (run[i] == DEB) begin
            mStable[i] = h2[i];
            if (h2[i]) mRise[i] = 1'b1;
            else       mFall[i] = 1'b1;
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      h2 = h1;
      h1 = sw_i;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int               errors = 0;
  int               checks = 0;
  logic             dirOn  = 1'b0;
  logic [WIDTH-1:0] dirExp = '0;

  always @(negedge clk) begin
    logic [31:0] e;
    checks++;
    if (sw_stable !== mStable) begin
      errors++;
      $display("FAIL sw_stable t=%0t got=%h exp=%h", $time, sw_stable, mStable);
    end
    checks++;
    if (evt_pending !== ((|mRise) | (|mFall))) begin
      errors++;
      $display("FAIL evt_pending t=%0t got=%b exp=%b", $time, evt_pending, (|mRise) | (|mFall));
    end
    checks++;
    if (rd_valid !== expValid) begin
      errors++;
      $display("FAIL rd_valid t=%0t got=%b exp=%b", $time, rd_valid, expValid);
    end
    if (expValid || rd_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected t=%0t got=%h exp=none", $time, rd_data);
      end else begin
        e = expQ.pop_front();
        checks++;
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data t=%0t got=%h exp=%h", $time, rd_data, e);
        end
        $display("read t=%0t data=%h exp=%h", $time, rd_data, e);
      end
    end else begin
      checks++;
      if (rd_data !== lastData) begin
        errors++;
        $display("FAIL rd_hold t=%0t got=%h exp=%h", $time, rd_data, lastData);
      end
    end
    if (dirOn) begin
      checks++;
      if (sw_stable !== dirExp) begin
        errors++;
        $display("FAIL directed_stable t=%0t got=%h exp=%h", $time, sw_stable, dirExp);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic expectStable(input logic [WIDTH-1:0] v);
    #1;
    dirExp = v;
    dirOn  = 1'b1;
    @(negedge clk);
    #1;
    dirOn = 1'b0;
  endtask

  task automatic doRead(input logic [1:0] s);
    @(negedge clk);
    rd_en  = 1'b1;
    rd_sel = s;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < WIDTH; i++) run[i] = 0;

    // reset with all inputs high: nothing accepted until edge 10
    rstn = 1'b0;
    sw_i = 16'hFFFF;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      expectStable(k < 10 ? 16'h0000 : 16'hFFFF);
    end
    doRead(2'd1);
    sw_i = 16'h0000;
    repeat (12) @(negedge clk);
    doRead(2'd2);

    // single bit rise: exact latency, then clear-on-read
    @(negedge clk);
    sw_i[3] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      expectStable(k < 10 ? 16'h0000 : 16'h0008);
    end
    doRead(2'd1);
    doRead(2'd1);

    // glitch shorter than the debounce window
    @(negedge clk);
    sw_i[0] = 1'b1;
    repeat (5) @(negedge clk);
    sw_i[0] = 1'b0;
    repeat (12) @(negedge clk);
    @(posedge clk);
    expectStable(16'h0008);
    doRead(2'd3);

    // fall on bit 7 committing on the same edge as a fall read
    @(negedge clk);
    sw_i[7] = 1'b1;
    repeat (12) @(negedge clk);
    doRead(2'd1);
    @(negedge clk);
    sw_i[7] = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rd_en  = 1'b1;
    rd_sel = 2'd2;
    @(negedge clk);
    rd_en = 1'b0;
    doRead(2'd2);

    // two bits changing three cycles apart
    @(negedge clk);
    sw_i[1] = 1'b1;
    repeat (3) @(negedge clk);
    sw_i[2] = 1'b1;
    repeat (14) @(negedge clk);
    doRead(2'd3);
    doRead(2'd1);
    doRead(2'd3);
    doRead(2'd0);

    // reset in the middle of a count on bit 5
    @(negedge clk);
    sw_i[5] = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (15) @(negedge clk);
    doRead(2'd1);

    // randomized traffic, including back-to-back reads and glitches
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rstn = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 5) == 0) begin
        int b;
        b = int'($urandom_range(0, WIDTH - 1));
        sw_i[b] = ~sw_i[b];
      end
      if ($urandom_range(0, 11) == 0) begin
        int g;
        g = int'($urandom_range(0, 3));
        sw_i[g] = ~sw_i[g];
      end
      rd_en  = ($urandom_range(0, 2) == 0);
      rd_sel = 2'($urandom_range(0, 3));
    end

    @(negedge clk);
    rstn  = 1'b1;
    rd_en = 1'b0;
    repeat (20) @(negedge clk);
    doRead(2'd1);
    doRead(2'd2);
    repeat (3) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
